// File: rtl/mem_port_arbiter.sv
// Shares one 256x32 memory between fetch (F) and load/store (D) via REQ/ACK, round-robin on ties.
// Latency: REQ sampled at edge 0, memory access in cycle 1, ACK plus registered data in cycle 2.
// Backpressure: a requester holds REQ until its ACK; the loser of a tie simply waits its turn.
// Optional: define MEM_ARB_WPROT_EN to block writes to addresses <= PROTECT_TOP and flag them on WPROT_ERR.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
`ifdef MEM_ARB_WPROT_EN
  ,
  parameter logic [ADDR_W-1:0] PROTECT_TOP = ADDR_W'(15)
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              F_REQ,
  input  logic [ADDR_W-1:0] F_ADDR,
  output logic              F_ACK,
  output logic [DATA_W-1:0] F_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_ACK,
  output logic [DATA_W-1:0] D_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR_READ,
  output logic [ADDR_W-1:0] MEM_ADDR_WRITE,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY
`ifdef MEM_ARB_WPROT_EN
  ,
  output logic              WPROT_ERR
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_F = 3'd1,
    SERVE_D = 3'd2,
    ACK_F   = 3'd3,
    ACK_D   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;      // 1: D was granted last, so F wins the next tie
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              wprot_err_q, wprot_err_d;
  logic              wr_blocked;

`ifdef MEM_ARB_WPROT_EN
  assign wr_blocked = (addr_q <= PROTECT_TOP);
  assign WPROT_ERR  = wprot_err_q;
`else
  assign wr_blocked = 1'b0;
`endif

  // State register; reset overrides every request in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      wprot_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      wprot_err_q <= wprot_err_d;
    end
  end

  // Next-state: grant from IDLE or straight from the ACK of the other side; capture reads in SERVE.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    wprot_err_d = wprot_err_q;
    unique case (state_q)
      IDLE: begin
        if (F_REQ && (!D_REQ || last_q)) begin
          state_d = SERVE_F;
          last_d  = 1'b0;
          addr_d  = F_ADDR;
          we_d    = 1'b0;
        end else if (D_REQ) begin
          state_d = SERVE_D;
          last_d  = 1'b1;
          addr_d  = D_ADDR;
          wdata_d = D_WDATA;
          we_d    = D_WE;
        end
      end
      SERVE_F: begin
        f_rdata_d = MEM_RDATA;
        state_d   = ACK_F;
      end
      SERVE_D: begin
        if (!we_q) begin
          d_rdata_d = MEM_RDATA;
        end else if (wr_blocked) begin
          wprot_err_d = 1'b1;
        end
        state_d = ACK_D;
      end
      ACK_F: begin
        // F_REQ is still high from the finished fetch; only D may be granted here.
        if (D_REQ) begin
          state_d = SERVE_D;
          last_d  = 1'b1;
          addr_d  = D_ADDR;
          wdata_d = D_WDATA;
          we_d    = D_WE;
        end else begin
          state_d = IDLE;
        end
      end
      ACK_D: begin
        if (F_REQ) begin
          state_d = SERVE_F;
          last_d  = 1'b0;
          addr_d  = F_ADDR;
          we_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs; write enable is masked by reset so an interrupted write never lands.
  always_comb begin
    MEM_ADDR_READ  = '0;
    MEM_ADDR_WRITE = '0;
    MEM_WDATA      = wdata_q;
    MEM_WE         = 1'b0;
    if (state_q == SERVE_F || state_q == SERVE_D) begin
      MEM_ADDR_READ  = addr_q;
      MEM_ADDR_WRITE = addr_q;
    end
    if (state_q == SERVE_D && we_q && !wr_blocked && !RESET) begin
      MEM_WE = 1'b1;
    end
  end

  assign F_ACK   = (state_q == ACK_F);
  assign D_ACK   = (state_q == ACK_D);
  assign F_RDATA = f_rdata_q;
  assign D_RDATA = d_rdata_q;
  assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256x32 memory (combinational read).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Build with MEM_ARB_WPROT_EN defined to exercise write protection.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        F_REQ;
  logic [7:0]  F_ADDR;
  logic        F_ACK;
  logic [31:0] F_RDATA;
  logic        D_REQ;
  logic        D_WE;
  logic [7:0]  D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_ACK;
  logic [31:0] D_RDATA;
  logic [7:0]  MEM_ADDR_READ;
  logic [7:0]  MEM_ADDR_WRITE;
  logic [31:0] MEM_WDATA;
  logic        MEM_WE;
  logic [31:0] MEM_RDATA;
  logic        BUSY;
`ifdef MEM_ARB_WPROT_EN
  logic        WPROT_ERR;
`endif

  logic [31:0] mem [0:255];
  logic        preload;
  int          checks = 0;
  int          failures = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_ACK(F_ACK), .F_RDATA(F_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .MEM_ADDR_READ(MEM_ADDR_READ), .MEM_ADDR_WRITE(MEM_ADDR_WRITE),
    .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RDATA(MEM_RDATA),
    .BUSY(BUSY)
`ifdef MEM_ARB_WPROT_EN
    , .WPROT_ERR(WPROT_ERR)
`endif
  );

  // Memory model: default word at address a is 0x3C0000aa, plus a few named words.
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= {24'h3C0000, i[7:0]};
      mem[8'h00] <= 32'h80400002;
      mem[8'h0B] <= 32'h55555555;
      mem[8'h30] <= 32'hCAFEF00D;
    end else if (MEM_WE) begin
      mem[MEM_ADDR_WRITE] <= MEM_WDATA;
    end
  end
  assign MEM_RDATA = mem[MEM_ADDR_READ];

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (MEM_WE !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%h exp=0", MEM_WE); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%h exp=0", BUSY); end
    checks++; if (F_ACK !== 1'b0 || D_ACK !== 1'b0) begin failures++; $display("FAIL rst_acks got=%h%h exp=00", F_ACK, D_ACK); end
    checks++; if (F_RDATA !== 32'h0) begin failures++; $display("FAIL rst_f_rdata got=%h exp=0", F_RDATA); end
    checks++; if (D_RDATA !== 32'h0) begin failures++; $display("FAIL rst_d_rdata got=%h exp=0", D_RDATA); end
    checks++; if (MEM_ADDR_READ !== 8'h00) begin failures++; $display("FAIL rst_addr_rd got=%h exp=00", MEM_ADDR_READ); end
`ifdef MEM_ARB_WPROT_EN
    checks++; if (WPROT_ERR !== 1'b0) begin failures++; $display("FAIL rst_wprot got=%h exp=0", WPROT_ERR); end
`endif
    RESET = 1'b0;
  endtask

  task automatic test_fetch_read();
    F_REQ = 1'b1; F_ADDR = 8'h00;
    @(negedge CLK); // cycle 1
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL fr_busy got=%h exp=1", BUSY); end
    checks++; if (MEM_ADDR_READ !== 8'h00) begin failures++; $display("FAIL fr_addr got=%h exp=00", MEM_ADDR_READ); end
    checks++; if (F_ACK !== 1'b0) begin failures++; $display("FAIL fr_ack_c1 got=%h exp=0", F_ACK); end
    F_ADDR = 8'h77;
    @(negedge CLK); // cycle 2
    checks++; if (F_ACK !== 1'b1) begin failures++; $display("FAIL fr_ack got=%h exp=1", F_ACK); end
    checks++; if (F_RDATA !== 32'h80400002) begin failures++; $display("FAIL fr_rdata got=%h exp=80400002", F_RDATA); end
    F_REQ = 1'b0;
    @(negedge CLK); // cycle 3
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL fr_idle got=%h exp=0", BUSY); end
    checks++; if (F_ACK !== 1'b0) begin failures++; $display("FAIL fr_ack_c3 got=%h exp=0", F_ACK); end
  endtask

  task automatic test_data_write_read();
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 8'h20; D_WDATA = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (MEM_WE !== 1'b1) begin failures++; $display("FAIL dw_we got=%h exp=1", MEM_WE); end
    checks++; if (MEM_ADDR_WRITE !== 8'h20) begin failures++; $display("FAIL dw_addr got=%h exp=20", MEM_ADDR_WRITE); end
    checks++; if (MEM_WDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL dw_wdata got=%h exp=deadbeef", MEM_WDATA); end
    D_ADDR = 8'h21; D_WDATA = 32'h0;
    @(negedge CLK);
    checks++; if (MEM_WE !== 1'b0) begin failures++; $display("FAIL dw_we_c2 got=%h exp=0", MEM_WE); end
    checks++; if (D_ACK !== 1'b1) begin failures++; $display("FAIL dw_ack got=%h exp=1", D_ACK); end
    checks++; if (D_RDATA !== 32'h0) begin failures++; $display("FAIL dw_rdata_hold got=%h exp=0", D_RDATA); end
    D_REQ = 1'b0;
    @(negedge CLK);
    checks++; if (mem[8'h20] !== 32'hDEADBEEF) begin failures++; $display("FAIL dw_mem20 got=%h exp=deadbeef", mem[8'h20]); end
    checks++; if (mem[8'h21] !== 32'h3C000021) begin failures++; $display("FAIL dw_mem21 got=%h exp=3c000021", mem[8'h21]); end
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 8'h20;
    @(negedge CLK);
    checks++; if (MEM_WE !== 1'b0) begin failures++; $display("FAIL dr_we got=%h exp=0", MEM_WE); end
    checks++; if (MEM_ADDR_READ !== 8'h20) begin failures++; $display("FAIL dr_addr got=%h exp=20", MEM_ADDR_READ); end
    @(negedge CLK);
    checks++; if (D_ACK !== 1'b1) begin failures++; $display("FAIL dr_ack got=%h exp=1", D_ACK); end
    checks++; if (D_RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL dr_rdata got=%h exp=deadbeef", D_RDATA); end
    D_REQ = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_contention();
    F_REQ = 1'b1; F_ADDR = 8'h01;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 8'h0B;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (c % 2 == 1) begin
        checks++; if (MEM_ADDR_READ !== ((c % 4 == 1) ? 8'h01 : 8'h0B)) begin failures++; $display("FAIL ct_addr c=%0d got=%h exp=%h", c, MEM_ADDR_READ, (c % 4 == 1) ? 8'h01 : 8'h0B); end
        checks++; if (F_ACK !== 1'b0 || D_ACK !== 1'b0) begin failures++; $display("FAIL ct_serve_acks c=%0d got=%h%h exp=00", c, F_ACK, D_ACK); end
      end else if (c % 4 == 2) begin
        checks++; if (F_ACK !== 1'b1 || D_ACK !== 1'b0) begin failures++; $display("FAIL ct_f_ack c=%0d got=%h%h exp=10", c, F_ACK, D_ACK); end
        checks++; if (F_RDATA !== 32'h3C000001) begin failures++; $display("FAIL ct_f_rdata c=%0d got=%h exp=3c000001", c, F_RDATA); end
      end else begin
        checks++; if (D_ACK !== 1'b1 || F_ACK !== 1'b0) begin failures++; $display("FAIL ct_d_ack c=%0d got=%h%h exp=01", c, F_ACK, D_ACK); end
        checks++; if (D_RDATA !== 32'h55555555) begin failures++; $display("FAIL ct_d_rdata c=%0d got=%h exp=55555555", c, D_RDATA); end
      end
    end
    F_REQ = 1'b0; D_REQ = 1'b0;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL ct_idle got=%h exp=0", BUSY); end
  endtask

  task automatic test_reset_in_serve();
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 8'h30; D_WDATA = 32'h0BADBEEF;
    @(negedge CLK); // SERVE_D
    checks++; if (MEM_WE !== 1'b1) begin failures++; $display("FAIL rs_we_pre got=%h exp=1", MEM_WE); end
    RESET = 1'b1;
    #1;
    checks++; if (MEM_WE !== 1'b0) begin failures++; $display("FAIL rs_we_masked got=%h exp=0", MEM_WE); end
    @(negedge CLK);
    checks++; if (D_ACK !== 1'b0) begin failures++; $display("FAIL rs_no_ack got=%h exp=0", D_ACK); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rs_busy got=%h exp=0", BUSY); end
    RESET = 1'b0; D_REQ = 1'b0;
    @(negedge CLK);
    checks++; if (D_ACK !== 1'b0) begin failures++; $display("FAIL rs_no_ack2 got=%h exp=0", D_ACK); end
    checks++; if (mem[8'h30] !== 32'hCAFEF00D) begin failures++; $display("FAIL rs_mem30 got=%h exp=cafef00d", mem[8'h30]); end
  endtask

  task automatic test_req_drop();
    int pulses = 0;
    F_REQ = 1'b1; F_ADDR = 8'hFF;
    @(negedge CLK); // SERVE_F
    checks++; if (MEM_ADDR_READ !== 8'hFF) begin failures++; $display("FAIL rd_addr got=%h exp=ff", MEM_ADDR_READ); end
    F_REQ = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      if (F_ACK === 1'b1) pulses++;
      if (c == 2) begin
        checks++; if (F_RDATA !== 32'h3C0000FF) begin failures++; $display("FAIL rd_rdata got=%h exp=3c0000ff", F_RDATA); end
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL rd_pulses got=%0d exp=1", pulses); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rd_idle got=%h exp=0", BUSY); end
  endtask

  task automatic test_wprot();
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 8'h05; D_WDATA = 32'h12345678;
    @(negedge CLK);
`ifdef MEM_ARB_WPROT_EN
    checks++; if (MEM_WE !== 1'b0) begin failures++; $display("FAIL wp_we_blocked got=%h exp=0", MEM_WE); end
    @(negedge CLK);
    checks++; if (D_ACK !== 1'b1) begin failures++; $display("FAIL wp_ack got=%h exp=1", D_ACK); end
    checks++; if (WPROT_ERR !== 1'b1) begin failures++; $display("FAIL wp_err got=%h exp=1", WPROT_ERR); end
    D_REQ = 1'b0;
    @(negedge CLK);
    checks++; if (mem[8'h05] !== 32'h3C000005) begin failures++; $display("FAIL wp_mem05 got=%h exp=3c000005", mem[8'h05]); end
    D_REQ = 1'b1; D_ADDR = 8'h10; D_WDATA = 32'hA0B0C0D0;
    @(negedge CLK);
    checks++; if (MEM_WE !== 1'b1) begin failures++; $display("FAIL wp_we_10 got=%h exp=1", MEM_WE); end
    @(negedge CLK);
    checks++; if (D_ACK !== 1'b1) begin failures++; $display("FAIL wp_ack_10 got=%h exp=1", D_ACK); end
    D_REQ = 1'b0;
    @(negedge CLK);
    checks++; if (mem[8'h10] !== 32'hA0B0C0D0) begin failures++; $display("FAIL wp_mem10 got=%h exp=a0b0c0d0", mem[8'h10]); end
    checks++; if (WPROT_ERR !== 1'b1) begin failures++; $display("FAIL wp_sticky got=%h exp=1", WPROT_ERR); end
`else
    checks++; if (MEM_WE !== 1'b1) begin failures++; $display("FAIL wp_we_open got=%h exp=1", MEM_WE); end
    @(negedge CLK);
    checks++; if (D_ACK !== 1'b1) begin failures++; $display("FAIL wp_ack got=%h exp=1", D_ACK); end
    D_REQ = 1'b0;
    @(negedge CLK);
    checks++; if (mem[8'h05] !== 32'h12345678) begin failures++; $display("FAIL wp_mem05 got=%h exp=12345678", mem[8'h05]); end
`endif
  endtask

  initial begin
    RESET = 1'b1; preload = 1'b1;
    F_REQ = 1'b0; F_ADDR = 8'h00;
    D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = 8'h00; D_WDATA = 32'h0;
    @(negedge CLK);
    preload = 1'b0;
    test_reset();
    test_fetch_read();
    test_data_write_read();
    test_reset();
    test_contention();
    test_reset_in_serve();
    test_req_drop();
    test_wprot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter that shares the 256x32 main memory between the instruction-fetch unit and the load/store unit. It owns the memory's read-address, write-address, write-data and write-enable inputs and serves one transaction at a time. Each requester uses a REQ/ACK handshake and gets registered read data. Ties are resolved round-robin. The block sits between the CPU core and the memory.

Parameters:
ADDR_W, 8, memory address width (256 words)
DATA_W, 32, memory word width
PROTECT_TOP, 8'd15, highest write-protected address (used only with MEM_ARB_WPROT_EN)

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  synchronous, active-high reset
F_REQ  in  1  fetch read request; held until F_ACK
F_ADDR  in  ADDR_W  fetch address
F_ACK  out  1  one-cycle completion pulse for fetch
F_RDATA  out  DATA_W  registered fetch read data
D_REQ  in  1  data request; held until D_ACK
D_WE  in  1  1 = write, 0 = read
D_ADDR  in  ADDR_W  data address
D_WDATA  in  DATA_W  write data
D_ACK  out  1  one-cycle completion pulse for data
D_RDATA  out  DATA_W  registered data read result
MEM_ADDR_READ  out  ADDR_W  to memory ADDRESS_READ
MEM_ADDR_WRITE  out  ADDR_W  to memory ADDRESS_WRITE
MEM_WDATA  out  DATA_W  to memory DATA_IN
MEM_WE  out  1  to memory WRITE_ENABLE
MEM_RDATA  in  DATA_W  from memory DATA_OUT (combinational read)
BUSY  out  1  high in any state except IDLE
WPROT_ERR  out  1  sticky protection violation flag; present only with MEM_ARB_WPROT_EN

Behaviour:
- Single clock CLK. RESET is synchronous, active-high, and wins over every other input.
- Reset values:
  - state = IDLE; LAST = D, so F wins the first tie.
  - F_ACK = D_ACK = 0, F_RDATA = D_RDATA = 0, BUSY = 0, WPROT_ERR = 0.
  - Latched address, write data and WE = 0.
- MEM_WE must be 0 in any cycle where RESET = 1.
- FSM states: IDLE, SERVE_F, SERVE_D, ACK_F, ACK_D.
- IDLE:
  - Only F_REQ high: go to SERVE_F.
  - Only D_REQ high: go to SERVE_D.
  - Both high: grant the requester that is not LAST.
  - On grant, latch that requester's ADDR (plus D_WE and D_WDATA for D) and update LAST.
- SERVE_x, one cycle:
  - MEM_ADDR_READ = MEM_ADDR_WRITE = latched address; MEM_WDATA = latched write data.
  - MEM_WE = 1 only in SERVE_D with latched WE = 1.
  - At the closing edge: on a read, capture MEM_RDATA into x_RDATA; go to ACK_x.
  - On a write, D_RDATA holds its value.
- ACK_x, one cycle:
  - x_ACK = 1, decoded from the registered state, so it is glitch-free.
  - The acked requester's REQ is ignored this cycle.
  - If the other requester's REQ is high, grant it directly (latch, go to SERVE_other, update LAST); otherwise go to IDLE.
- Outside SERVE states: MEM_ADDR_READ = MEM_ADDR_WRITE = 0, MEM_WE = 0.
- Timing:
  - Latency: REQ sampled at edge 0, SERVE in cycle 1, ACK in cycle 2; data is valid on the same cycle as ACK.
  - Throughput: one transaction per 2 cycles under continuous contention, strictly alternating F, D, F, D.
  - A single requester needs 3 cycles per transaction because it returns through IDLE.
- Boundary conditions:
  - REQ dropped after grant: the transaction still completes and ACK still pulses once.
  - Address or data changed after grant: ignored, since values are latched.
  - RESET during SERVE_D: no write performed, no ACK, IDLE on the next cycle.
  - Addresses 0x00 and 0xFF need no special handling; there is no wrap logic.

Optional Feature:
MEM_ARB_WPROT_EN.
- Defined:
  - A write with latched address <= PROTECT_TOP keeps MEM_WE = 0 during SERVE_D.
  - D_ACK still pulses normally.
  - WPROT_ERR is set at the SERVE_D closing edge and stays set until RESET.
- Undefined: the WPROT_ERR port and its logic are absent, and all writes are performed.

Test Plan:
1. Memory word 0x00 = 0x80400002; after RESET, F_REQ = 1 with F_ADDR = 0x00 -> cycle 1: BUSY = 1 and MEM_ADDR_READ = 0x00; cycle 2: F_ACK = 1 and F_RDATA = 0x80400002; cycle 3: IDLE.
2. D write 0x20 <- 0xDEADBEEF -> MEM_WE = 1 for exactly one cycle with MEM_ADDR_WRITE = 0x20, then D_ACK. A following D read of 0x20 -> D_RDATA = 0xDEADBEEF.
3. After RESET, F_REQ (addr 0x01) and D_REQ (addr 0x0B, word 0x55555555) asserted together and held -> F served first (ACK cycle 2), SERVE_D in cycle 3, D_ACK in cycle 4 with D_RDATA = 0x55555555, then F again; grants alternate F, D, F, D.
4. RESET asserted during SERVE_D of a write to 0x30 -> MEM_WE = 0 that cycle, no D_ACK, BUSY = 0 next cycle, and word 0x30 unchanged.
5. F_REQ dropped during SERVE_F -> F_ACK pulses exactly once and F is not re-granted.
6. With MEM_ARB_WPROT_EN: write 0x05 <- 0x12345678 -> MEM_WE stays 0, D_ACK pulses, WPROT_ERR = 1 and stays set. A write to 0x10 then proceeds with MEM_WE = 1.
